traffic_light_monitor: RTL and testbench

Passive observer on the red/yellow/green outputs of the traffic-light controller; the receiving end of the lamp interface.
- Decodes the lamp pattern into a phase and checks legal phase order and per-phase dwell times.
- Reports errors as single-cycle pulses plus sticky flags, and counts completed light cycles.
- Used as a bench checker and as an on-chip safety monitor.

---
 rtl/traffic_pkg.sv | 61 ++++++
 rtl/traffic_dwell_cnt.sv | 49 ++++
 rtl/traffic_light_monitor.sv | 168 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its lamp monitor:
// phase encoding, lamp patterns, error bit positions and phase helpers.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_RED    = 2'd0,
      PH_RY     = 2'd1,
      PH_GREEN  = 2'd2,
      PH_YELLOW = 2'd3
   } phase_t;

   // Lamp patterns as {red, yellow, green}
   localparam logic [2:0] PAT_RED    = 3'b100;
   localparam logic [2:0] PAT_RY     = 3'b110;
   localparam logic [2:0] PAT_GREEN  = 3'b001;
   localparam logic [2:0] PAT_YELLOW = 3'b010;

   // Bit positions inside the error pulse / sticky vectors
   localparam int ERR_PATTERN = 0;
   localparam int ERR_ORDER   = 1;
   localparam int ERR_TIME    = 2;
   localparam int ERR_STUCK   = 3;

   // Legal successor in the fixed light sequence
   function automatic phase_t next_phase(input phase_t ph);
      phase_t nxt;
      case (ph)
         PH_RED:    nxt = PH_RY;
         PH_RY:     nxt = PH_GREEN;
         PH_GREEN:  nxt = PH_YELLOW;
         PH_YELLOW: nxt = PH_RED;
         default:   nxt = PH_RED;
      endcase
      return nxt;
   endfunction

   // True for the four lamp combinations the controller may show
   function automatic logic pat_is_legal(input logic [2:0] pat);
      logic legal;
      case (pat)
         PAT_RED, PAT_RY, PAT_GREEN, PAT_YELLOW: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Phase shown by a legal pattern; illegal patterns map to PH_RED and
   // must be filtered with pat_is_legal first
   function automatic phase_t pat_to_phase(input logic [2:0] pat);
      phase_t ph;
      case (pat)
         PAT_RED:    ph = PH_RED;
         PAT_RY:     ph = PH_RY;
         PAT_GREEN:  ph = PH_GREEN;
         PAT_YELLOW: ph = PH_YELLOW;
         default:    ph = PH_RED;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/traffic_dwell_cnt.sv
// Saturating dwell counter for the lamp monitor. Load sets it to 1 (first
// clock of a new phase), increment adds one and sticks at all-ones.
// o_hit_max flags that the next increment lands exactly on MAX_DWELL.
module traffic_dwell_cnt #(
   parameter int CNT_W     = 8,
   parameter int MAX_DWELL = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_hit_max
);

   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DWELL);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   // Incremented value, held at all-ones once saturated
   always_comb begin
      w_cnt_inc = r_cnt;
      if (r_cnt == CNT_SAT) begin
         w_cnt_inc = r_cnt;
      end else begin
         w_cnt_inc = r_cnt + CNT_ONE;
      end
   end

   assign o_hit_max = (w_cnt_inc == CNT_MAX) && (r_cnt != CNT_MAX);
   assign o_cnt     = r_cnt;

   // Counter register: load has priority over increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_load) begin
         r_cnt <= CNT_ONE;
      end else if (i_inc) begin
         r_cnt <= w_cnt_inc;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor on the controller's lamp outputs. Registers the lamp
// pattern, follows the RED->RY->GREEN->YELLOW sequence, checks dwell times
// and reports single-cycle error pulses, sticky flags and a cycle count.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int RY_LEN     = 2,
   parameter int YELLOW_LEN = 3,
   parameter int MIN_RED    = 5,
   parameter int MIN_GREEN  = 5,
   parameter int MAX_DWELL  = 64,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red,
   input  logic        yellow,
   input  logic        green,
   input  logic        clr,
   output logic [1:0]  phase,
   output logic        in_sync,
   output logic        err_pattern,
   output logic        err_order,
   output logic        err_time,
   output logic        err_stuck,
   output logic [3:0]  err_sticky,
   output logic [15:0] cycles
);

   typedef enum logic {ST_SYNC = 1'b0, ST_TRACK = 1'b1} state_t;

   logic [2:0]       r_pat_q;
   logic [2:0]       r_pat_prev;
   logic             r_pat_vld;
   state_t           r_state;
   phase_t           r_phase;
   logic             r_in_sync;
   logic [3:0]       r_err;
   logic [3:0]       r_sticky;
   logic [15:0]      r_cycles;

   state_t           w_state_nxt;
   phase_t           w_phase_nxt;
   phase_t           w_pat_phase;
   logic             w_red_onset;
   logic             w_time_bad;
   logic [3:0]       w_err_nxt;
   logic [15:0]      w_cycles_nxt;
   logic             w_dwell_load;
   logic             w_dwell_inc;
   logic             w_hit_max;
   logic [CNT_W-1:0] w_dwell;

   traffic_dwell_cnt #(
      .CNT_W     (CNT_W),
      .MAX_DWELL (MAX_DWELL)
   ) u_dwell (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_dwell_load),
      .i_inc     (w_dwell_inc),
      .o_cnt     (w_dwell),
      .o_hit_max (w_hit_max)
   );

   // Locking needs a fresh RED onset so the first RED dwell is measured
   // from its real start; the reset value 000 of pat_q counts as non-RED.
   assign w_pat_phase = pat_to_phase(r_pat_q);
   assign w_red_onset = (r_pat_q == PAT_RED) && (r_pat_prev != PAT_RED);

   // Dwell rule for the phase being left
   always_comb begin
      w_time_bad = 1'b0;
      case (r_phase)
         PH_RED:    w_time_bad = (w_dwell <  CNT_W'(MIN_RED));
         PH_RY:     w_time_bad = (w_dwell != CNT_W'(RY_LEN));
         PH_GREEN:  w_time_bad = (w_dwell <  CNT_W'(MIN_GREEN));
         PH_YELLOW: w_time_bad = (w_dwell != CNT_W'(YELLOW_LEN));
         default:   w_time_bad = 1'b0;
      endcase
   end

   // Next-state, phase tracking and error pulse decode. pat_q is ignored on
   // the first edge after reset because it still holds the cleared value.
   always_comb begin
      w_state_nxt  = r_state;
      w_phase_nxt  = r_phase;
      w_err_nxt    = 4'b0000;
      w_cycles_nxt = r_cycles;
      w_dwell_load = 1'b0;
      w_dwell_inc  = 1'b0;
      if (!r_pat_vld) begin
         w_state_nxt = r_state;
      end else if (!pat_is_legal(r_pat_q)) begin
         w_err_nxt[ERR_PATTERN] = 1'b1;
         w_state_nxt            = ST_SYNC;
      end else begin
         case (r_state)
            ST_SYNC: begin
               if (w_red_onset) begin
                  w_state_nxt  = ST_TRACK;
                  w_phase_nxt  = PH_RED;
                  w_dwell_load = 1'b1;
               end else begin
                  w_state_nxt  = ST_SYNC;
               end
            end
            ST_TRACK: begin
               if (w_pat_phase == r_phase) begin
                  w_dwell_inc          = 1'b1;
                  w_err_nxt[ERR_STUCK] = w_hit_max;
               end else if (w_pat_phase == next_phase(r_phase)) begin
                  w_err_nxt[ERR_TIME]  = w_time_bad;
                  w_phase_nxt          = w_pat_phase;
                  w_dwell_load         = 1'b1;
                  if (r_phase == PH_YELLOW) begin
                     w_cycles_nxt = r_cycles + 16'd1;
                  end else begin
                     w_cycles_nxt = r_cycles;
                  end
               end else begin
                  w_err_nxt[ERR_ORDER] = 1'b1;
                  w_state_nxt          = ST_SYNC;
               end
            end
            default: begin
               w_state_nxt = ST_SYNC;
            end
         endcase
      end
   end

   // State, input capture and registered outputs; a pulse in the same cycle
   // as clr still sets its sticky bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pat_q    <= 3'b000;
         r_pat_prev <= 3'b000;
         r_pat_vld  <= 1'b0;
         r_state    <= ST_SYNC;
         r_phase    <= PH_RED;
         r_in_sync  <= 1'b0;
         r_err      <= 4'b0000;
         r_sticky   <= 4'b0000;
         r_cycles   <= 16'd0;
      end else begin
         r_pat_q    <= {red, yellow, green};
         r_pat_prev <= r_pat_q;
         r_pat_vld  <= 1'b1;
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_in_sync  <= (w_state_nxt == ST_TRACK);
         r_err      <= w_err_nxt;
         r_sticky   <= (clr ? 4'b0000 : r_sticky) | w_err_nxt;
         r_cycles   <= w_cycles_nxt;
      end
   end

   assign phase       = r_phase;
   assign in_sync     = r_in_sync;
   assign err_pattern = r_err[ERR_PATTERN];
   assign err_order   = r_err[ERR_ORDER];
   assign err_time    = r_err[ERR_TIME];
   assign err_stuck   = r_err[ERR_STUCK];
   assign err_sticky  = r_sticky;
   assign cycles      = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed lamp sequences followed by
// randomized ones, every cycle compared against a behavioural model.
module tb_traffic_light_monitor;

   localparam int RY_LEN     = 2;
   localparam int YELLOW_LEN = 3;
   localparam int MIN_RED    = 5;
   localparam int MIN_GREEN  = 5;
   localparam int MAX_DWELL  = 64;
   localparam int CNT_W      = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        red, yellow, green, clr;
   logic [1:0]  phase;
   logic        in_sync, err_pattern, err_order, err_time, err_stuck;
   logic [3:0]  err_sticky;
   logic [15:0] cycles;

   traffic_light_monitor #(
      .RY_LEN(RY_LEN), .YELLOW_LEN(YELLOW_LEN), .MIN_RED(MIN_RED),
      .MIN_GREEN(MIN_GREEN), .MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
      .clr(clr), .phase(phase), .in_sync(in_sync),
      .err_pattern(err_pattern), .err_order(err_order),
      .err_time(err_time), .err_stuck(err_stuck),
      .err_sticky(err_sticky), .cycles(cycles)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Lamp tables: index = phase number in sequence order
   logic [2:0] lamp_pat [4];
   logic [2:0] bad_pat  [4];

   int n_chk  = 0;
   int n_pass = 0;
   int n_stuck_seen = 0;

   // Reference model state
   logic [2:0] m_pat_q, m_pat_prev;
   bit         m_vld, m_locked;
   int         m_ph, m_dwell, m_cycles;
   logic [3:0] m_sticky, m_pulse;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int pat_index(input logic [2:0] p);
      for (int i = 0; i < 4; i++) if (lamp_pat[i] == p) return i;
      return -1;
   endfunction

   function automatic bit dwell_ok(input int ph, input int d);
      case (ph)
         0:       return d >= MIN_RED;
         1:       return d == RY_LEN;
         2:       return d >= MIN_GREEN;
         default: return d == YELLOW_LEN;
      endcase
   endfunction

   task automatic model_reset();
      m_pat_q = 3'b000; m_pat_prev = 3'b000; m_vld = 1'b0; m_locked = 1'b0;
      m_ph = 0; m_dwell = 0; m_cycles = 0; m_sticky = 4'b0000; m_pulse = 4'b0000;
   endtask

   // One clock edge of the model: judge the previously captured pattern
   task automatic model_edge(input logic [2:0] pat_in, input bit clr_in);
      int k;
      m_pulse = 4'b0000;
      if (m_vld) begin
         k = pat_index(m_pat_q);
         if (k < 0) begin
            m_pulse[0] = 1'b1; m_locked = 1'b0;
         end else if (!m_locked) begin
            if (k == 0 && m_pat_prev != lamp_pat[0]) begin
               m_locked = 1'b1; m_ph = 0; m_dwell = 1;
            end
         end else if (k == m_ph) begin
            if (m_dwell < (1 << CNT_W) - 1) begin
               m_dwell++;
               if (m_dwell == MAX_DWELL) m_pulse[3] = 1'b1;
            end
         end else if (k == (m_ph + 1) % 4) begin
            if (!dwell_ok(m_ph, m_dwell)) m_pulse[2] = 1'b1;
            if (m_ph == 3) m_cycles = (m_cycles + 1) % 65536;
            m_ph = k; m_dwell = 1;
         end else begin
            m_pulse[1] = 1'b1; m_locked = 1'b0;
         end
      end
      m_sticky   = (clr_in ? 4'b0000 : m_sticky) | m_pulse;
      m_pat_prev = m_pat_q;
      m_pat_q    = pat_in;
      m_vld      = 1'b1;
   endtask

   task automatic compare_all();
      check_val("phase",   32'(phase), 32'(m_ph));
      check_val("in_sync", 32'(in_sync), 32'(m_locked));
      check_val("pulses",  32'({err_stuck, err_time, err_order, err_pattern}), 32'(m_pulse));
      check_val("sticky",  32'(err_sticky), 32'(m_sticky));
      check_val("cycles",  32'(cycles), 32'(m_cycles));
   endtask

   task automatic step(input logic [2:0] pat, input bit c);
      {red, yellow, green} = pat;
      clr = c;
      @(posedge clk);
      model_edge(pat, c);
      #1;
      if (err_stuck) n_stuck_seen++;
      compare_all();
   endtask

   task automatic hold(input logic [2:0] pat, input int n, input bit rnd_clr);
      for (int i = 0; i < n; i++)
         step(pat, rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_phase"},  32'(phase), 32'd0);
      check_val({tag, "_sync"},   32'(in_sync), 32'd0);
      check_val({tag, "_pulses"}, 32'({err_stuck, err_time, err_order, err_pattern}), 32'd0);
      check_val({tag, "_sticky"}, 32'(err_sticky), 32'd0);
      check_val({tag, "_cycles"}, 32'(cycles), 32'd0);
   endtask

   // Directed scenarios, then randomized sequences
   initial begin
      lamp_pat[0] = 3'b100; lamp_pat[1] = 3'b110;
      lamp_pat[2] = 3'b001; lamp_pat[3] = 3'b010;
      bad_pat[0]  = 3'b000; bad_pat[1]  = 3'b011;
      bad_pat[2]  = 3'b101; bad_pat[3]  = 3'b111;

      rst = 1'b1; clr = 1'b0;
      {red, yellow, green} = 3'b100;
      #1 rst = 1'b0;
      #1 check_reset_outputs("por");
      model_reset();
      #20 rst = 1'b1;                       // released at t=22, between edges

      // Clean sequence: one full cycle, no errors
      hold(3'b100, 5, 1'b0); hold(3'b110, 2, 1'b0);
      hold(3'b001, 5, 1'b0); hold(3'b010, 3, 1'b0);
      hold(3'b100, 3, 1'b0);
      check_val("seq_cycles", 32'(cycles), 32'd1);
      check_val("seq_sticky", 32'(err_sticky), 32'd0);

      // RED only 4 clocks -> dwell violation on entering RY
      hold(3'b100, 1, 1'b0); hold(3'b110, 2, 1'b0);
      check_val("short_red_sticky", 32'(err_sticky), 32'h4);
      hold(3'b001, 5, 1'b0); hold(3'b010, 3, 1'b0);
      hold(3'b100, 5, 1'b0); hold(3'b110, 2, 1'b0);

      // RED straight after GREEN -> order error, held RED does not relock
      hold(3'b001, 3, 1'b0); hold(3'b100, 4, 1'b0);
      check_val("order_sync", 32'(in_sync), 32'd0);
      hold(3'b010, 2, 1'b0); hold(3'b100, 5, 1'b0);
      check_val("relock_sync", 32'(in_sync), 32'd1);
      hold(3'b110, 2, 1'b0); hold(3'b001, 3, 1'b0);

      // Illegal pattern mid-GREEN, then clr in the same cycle as a new pulse
      step(3'b101, 1'b0); step(3'b111, 1'b0); step(3'b111, 1'b1);
      check_val("clr_set_wins", 32'(err_sticky), 32'h1);

      // GREEN held 70 clocks -> exactly one stuck pulse
      hold(3'b100, 5, 1'b0); hold(3'b110, 2, 1'b0);
      n_stuck_seen = 0;
      hold(3'b001, 70, 1'b0); hold(3'b010, 1, 1'b0);
      check_val("stuck_count", 32'(n_stuck_seen), 32'd1);

      // Async reset mid-YELLOW, visible before any clock edge
      #2 rst = 1'b0;
      #1 check_reset_outputs("async");
      model_reset();
      #2 rst = 1'b1;
      hold(3'b010, 3, 1'b0);
      check_val("wait_red", 32'(in_sync), 32'd0);
      hold(3'b100, 5, 1'b0); hold(3'b110, 2, 1'b0);
      hold(3'b001, 5, 1'b0); hold(3'b010, 3, 1'b0);

      // Randomized sequences with boundary dwells and occasional faults
      for (int r = 0; r < 40; r++) begin
         for (int p = 0; p < 4; p++) begin
            int roll;
            int len;
            roll = $urandom_range(0, 19);
            if (roll == 0) hold(bad_pat[$urandom_range(0, 3)], 1, 1'b1);
            else if (roll == 1) hold(lamp_pat[$urandom_range(0, 3)], $urandom_range(1, 3), 1'b1);
            case (p)
               0:       len = $urandom_range(3, 7);
               1:       len = $urandom_range(1, 3);
               2:       len = $urandom_range(3, 7);
               default: len = $urandom_range(2, 4);
            endcase
            hold(lamp_pat[p], len, 1'b1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
